fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 48 ++++
 rtl/fetch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//   Groups the fetch controller's bus signals.
//
//   Redirect:   redirect_i, redirect_addr_i
//   I-memory:   instr_req_o, instr_addr_o, instr_gnt_i, instr_rvalid_i, instr_rdata_i
//   Decoder:    instr_valid_o, instr_o, instr_pc_o, instr_ready_i
//
//   The _i/_o suffixes are seen from the fetch controller.
//   - master: the fetch controller.
//   - slave:  the environment (memory, decoder, branch unit).
//
//   Handshakes:
//   - Memory: a request is accepted in a cycle where instr_req_o and
//     instr_gnt_i are both high. instr_rvalid_i returns data for the oldest
//     accepted request, one or more cycles later.
//   - Decoder: the head entry is consumed in a cycle where instr_valid_o and
//     instr_ready_i are both high. Otherwise the head is held unchanged.
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  redirect_i;
    logic [ADDR_WIDTH-1:0] redirect_addr_i;

    logic                  instr_req_o;
    logic [ADDR_WIDTH-1:0] instr_addr_o;
    logic                  instr_gnt_i;
    logic                  instr_rvalid_i;
    logic [31:0]           instr_rdata_i;

    logic                  instr_valid_o;
    logic [31:0]           instr_o;
    logic [ADDR_WIDTH-1:0] instr_pc_o;
    logic                  instr_ready_i;

    modport master (
        input  redirect_i, redirect_addr_i,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_ready_i,
        output instr_req_o, instr_addr_o, instr_valid_o, instr_o, instr_pc_o
    );

    modport slave (
        output redirect_i, redirect_addr_i,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_ready_i,
        input  instr_req_o, instr_addr_o, instr_valid_o, instr_o, instr_pc_o
    );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction fetch controller. It keeps one request outstanding and buffers
//   returned words in a 2-entry FIFO of {pc, instr}. Redirects restart fetch
//   at a new word-aligned address and flush the FIFO.
//
//   Ports
//   - clk          : clock, rising edge
//   - rst_n        : synchronous, active-low reset
//   - bus          : fetch_ctrl_if.master (memory, decoder and redirect signals)
//   - state_dbg_o  : current FSM state
//                    (0 = IDLE, 1 = REQ, 2 = WAIT, 3 = FLUSH)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_ctrl_if.master      bus,
    output logic [1:0]        state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] pc_mem_q  [2];
    logic [ADDR_WIDTH-1:0] pc_mem_d  [2];
    logic [31:0]           ins_mem_q [2];
    logic [31:0]           ins_mem_d [2];

    logic                  req;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] redir_addr;
    logic                  unused_redir_lsb;

    // Redirect targets are forced onto a word boundary.
    assign redir_addr       = {bus.redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redir_lsb = ^bus.redirect_addr_i[1:0];

    // A request is only raised while the FIFO has room. Its response can then
    // always be pushed, even if the decoder never pops.
    assign req = (state_q == REQ) && (count_q != 2'd2);
    assign pop = (count_q != 2'd0) && bus.instr_ready_i;

    always_comb begin
        state_d = state_q;
        faddr_d = faddr_q;
        push    = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;

            REQ: begin
                if (req && bus.instr_gnt_i) begin
                    if (bus.redirect_i) begin
                        // The granted word is now stale. Its response must be dropped.
                        state_d = FLUSH;
                        faddr_d = redir_addr;
                    end else begin
                        state_d = WAIT;
                        faddr_d = faddr_q + WORD_STEP;
                    end
                end else if (bus.redirect_i) begin
                    faddr_d = redir_addr;
                end
            end

            WAIT: begin
                if (bus.instr_rvalid_i) begin
                    state_d = REQ;
                    if (bus.redirect_i) begin
                        faddr_d = redir_addr;
                    end else begin
                        push = 1'b1;
                    end
                end else if (bus.redirect_i) begin
                    faddr_d = redir_addr;
                    state_d = FLUSH;
                end
            end

            FLUSH: begin
                if (bus.redirect_i) begin
                    faddr_d = redir_addr;
                end
                // Nothing is outstanding once the dropped response arrives.
                // This holds even if a new redirect comes in the same cycle.
                if (bus.instr_rvalid_i) begin
                    state_d = REQ;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // FIFO update. A redirect empties the FIFO, which overrides any pop in
    // the same cycle. A push never coincides with a redirect.
    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        pc_mem_d  = pc_mem_q;
        ins_mem_d = ins_mem_q;

        if (bus.redirect_i) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                // faddr has already advanced past the word being returned.
                pc_mem_d[wr_ptr_q]  = faddr_q - WORD_STEP;
                ins_mem_d[wr_ptr_q] = bus.instr_rdata_i;
                wr_ptr_d            = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            faddr_q  <= BOOT_ADDR;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            faddr_q   <= faddr_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            pc_mem_q  <= pc_mem_d;
            ins_mem_q <= ins_mem_d;
        end
    end

    assign bus.instr_req_o   = req;
    assign bus.instr_addr_o  = faddr_q;
    assign bus.instr_valid_o = (count_q != 2'd0);
    assign bus.instr_o       = ins_mem_q[rd_ptr_q];
    assign bus.instr_pc_o    = pc_mem_q[rd_ptr_q];
    assign state_dbg_o       = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Self-checking bench for fetch_ctrl.
//   - A transaction-level model tracks the next fetch address, the single
//     outstanding request and the words that should reach the decoder.
//   - The model pushes expected {pc, instr} words into exp_q.
//   - A monitor pops exp_q and compares on every decoder handshake.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
    localparam int              AW   = 32;
    localparam logic [AW-1:0]   BOOT = 32'h0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;

    fetch_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fetch_ctrl #(.ADDR_WIDTH(AW), .BOOT_ADDR(BOOT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [AW+31:0] exp_q[$];
    logic [AW-1:0]  exp_addr    = BOOT;
    logic [AW-1:0]  out_addr    = '0;
    bit             outstanding = 0;
    bit             killed      = 0;
    bit             in_idle     = 0;
    bit             live        = 0;
    int             dly_cnt     = 0;
    int             pop_cnt     = 0;
    bit             seen_pc8    = 0;

    // ---------------- stimulus knobs ----------------
    int            gnt_pct   = 100;
    int            rdy_pct   = 100;
    int            redir_pct = 0;
    int            dly_lo    = 0;
    int            dly_hi    = 0;
    bit            frc_redir  = 0;
    bit            frc_rvalid = 0;
    logic [AW-1:0] frc_addr   = '0;

    // The model sees each cycle's inputs at the falling edge. It first checks
    // the outputs, then predicts the effect of the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_addr    = BOOT;
            outstanding = 0;
            killed      = 0;
            in_idle     = 1;
            live        = 1;
        end else if (live) begin
            bit exp_req;
            exp_req = !in_idle && !outstanding && (exp_q.size() < 2);
            check("valid", bus.instr_valid_o, exp_q.size() != 0);
            check("req", bus.instr_req_o, exp_req);
            if (exp_req) check("req_addr", bus.instr_addr_o, exp_addr);

            if (bus.instr_rvalid_i && outstanding) begin
                if (!killed && !bus.redirect_i) exp_q.push_back({out_addr, bus.instr_rdata_i});
                outstanding = 0;
            end
            if (exp_req && bus.instr_gnt_i) begin
                outstanding = 1;
                killed      = 0;
                out_addr    = exp_addr;
                exp_addr    = exp_addr + 4;
                dly_cnt     = $urandom_range(dly_hi, dly_lo);
            end
            if (bus.redirect_i) begin
                if (outstanding) killed = 1;
                exp_addr = {bus.redirect_addr_i[AW-1:2], 2'b00};
                exp_q.delete();
            end
            in_idle = 0;
        end
    end

    // Monitor: compares the FIFO head on each decoder handshake.
    // A pop in a redirect cycle is flushed rather than delivered.
    always @(negedge clk) begin
        #1;
        if (rst_n && live) begin
            if (bus.instr_valid_o && bus.instr_pc_o == 32'h8) seen_pc8 = 1;
            if (bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i) begin
                logic [AW+31:0] e;
                pop_cnt++;
                check("pop_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("head_pc", bus.instr_pc_o, e[AW+31:32]);
                    check("head_instr", bus.instr_o, e[31:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic [AW-1:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 5)      return AW'($urandom_range(0, 255));
        else if (sel < 7) return 32'hFFFF_FFF0 | AW'($urandom_range(0, 15));
        else              return $urandom;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        bus.instr_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
        bus.instr_ready_i  = ($urandom_range(0, 99) < rdy_pct);
        bus.instr_rdata_i  = $urandom;
        bus.instr_rvalid_i = frc_rvalid;
        if (outstanding && rst_n) begin
            if (dly_cnt == 0) bus.instr_rvalid_i = 1'b1;
            else dly_cnt--;
        end
        bus.redirect_i      = frc_redir || ($urandom_range(0, 99) < redir_pct);
        bus.redirect_addr_i = frc_redir ? frc_addr : rand_addr();
        frc_redir  = 0;
        frc_rvalid = 0;
    endtask

    task automatic step();
        tick();
        drive();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) step();
        check("rst_req", bus.instr_req_o, 1'b0);
        check("rst_valid", bus.instr_valid_o, 1'b0);
        check("rst_instr", bus.instr_o, 32'h0);
        check("rst_pc", bus.instr_pc_o, 32'h0);
        check("rst_state_idle", state_dbg, 2'd0);
        rst_n = 1'b1;
    endtask

    // Runs until instr_req_o is seen, leaving this cycle's inputs undriven.
    task automatic wait_req(input string name, output bit found);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.instr_req_o) begin
                found = 1;
                break;
            end
            drive();
        end
        check(name, found, 1'b1);
    endtask

    initial begin
        bit found;
        int p0;

        bus.redirect_i      = 1'b0;
        bus.redirect_addr_i = '0;
        bus.instr_gnt_i     = 1'b0;
        bus.instr_rvalid_i  = 1'b0;
        bus.instr_rdata_i   = '0;
        bus.instr_ready_i   = 1'b0;

        // Streaming: one instruction every two cycles, pc 0, 4, 8, ...
        gnt_pct = 100; rdy_pct = 100; redir_pct = 0; dly_lo = 0; dly_hi = 0;
        do_reset(3);
        repeat (10) step();
        p0 = pop_cnt;
        repeat (20) step();
        check("stream_rate", pop_cnt - p0, 10);

        // Backpressure: FIFO fills with 0x0 and 0x4, then requests stop.
        rdy_pct = 0;
        do_reset(2);
        repeat (12) step();
        check("bp_req_off", bus.instr_req_o, 1'b0);
        check("bp_valid", bus.instr_valid_o, 1'b1);
        check("bp_head_pc", bus.instr_pc_o, 32'h0);
        rdy_pct = 100;
        repeat (8) step();

        // Redirect while waiting for the 0x8 response.
        dly_lo = 3; dly_hi = 3;
        do_reset(2);
        seen_pc8 = 0;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (outstanding && out_addr == 32'h8 && dly_cnt > 0) begin
                found = 1;
                break;
            end
            drive();
        end
        check("wait_redirect_reached", found, 1'b1);
        frc_redir = 1; frc_addr = 32'h100;
        drive();
        wait_req("wait_redirect_req", found);
        check("wait_redirect_addr", bus.instr_addr_o, 32'h100);
        drive();
        repeat (20) step();
        check("no_pc8", seen_pc8, 1'b0);

        // Redirect coincident with grant: flush, then fetch 0x200.
        gnt_pct = 0; dly_lo = 2; dly_hi = 2;
        do_reset(2);
        wait_req("gnt_redirect_req0", found);
        gnt_pct = 100; frc_redir = 1; frc_addr = 32'h200;
        drive();
        tick();
        check("gnt_redirect_flush_noreq", bus.instr_req_o, 1'b0);
        drive();
        wait_req("gnt_redirect_req1", found);
        check("gnt_redirect_addr", bus.instr_addr_o, 32'h200);
        drive();
        repeat (10) step();

        // Unaligned redirect target is word-aligned.
        gnt_pct = 0;
        do_reset(2);
        wait_req("align_req0", found);
        frc_redir = 1; frc_addr = 32'h103;
        drive();
        tick();
        check("align_req", bus.instr_req_o, 1'b1);
        check("align_addr", bus.instr_addr_o, 32'h100);
        drive();

        // Reset during WAIT, then a stale rvalid.
        gnt_pct = 100; dly_lo = 5; dly_hi = 5;
        do_reset(2);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (outstanding) begin
                found = 1;
                break;
            end
            drive();
        end
        check("rst_wait_reached", found, 1'b1);
        rst_n = 1'b0;
        drive();
        tick();
        frc_rvalid = 1;
        drive();
        tick();
        rst_n = 1'b1;
        frc_rvalid = 1;
        drive();
        wait_req("rst_wait_req", found);
        check("rst_wait_boot_addr", bus.instr_addr_o, BOOT);
        check("rst_wait_no_push", bus.instr_valid_o, 1'b0);
        drive();
        repeat (10) step();

        // Randomized traffic.
        for (int blk = 0; blk < 8; blk++) begin
            gnt_pct   = $urandom_range(20, 100);
            rdy_pct   = $urandom_range(0, 100);
            redir_pct = $urandom_range(0, 15);
            dly_lo    = 0;
            dly_hi    = $urandom_range(0, 4);
            for (int i = 0; i < 100; i++) begin
                step();
                if ($urandom_range(0, 299) == 0) do_reset(2);
            end
        end

        redir_pct = 0; rdy_pct = 100; gnt_pct = 100;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
